// File: rtl/cam_pixel_capture_if.sv
// cam_pixel_capture_if
//   Bundles the OV7670 parallel camera bus and the frame-buffer write port
//   that the capture stage produces.
//   slave  : capture-stage view (camera bus in, BRAM write port out)
//   master : environment view (drives the camera bus, observes writes)
//   Signals:
//     vsync      camera frame sync, high = vertical blanking
//     href       camera line valid, high = active bytes on d
//     d          camera data byte
//     addr       BRAM write address
//     dout       pixel {B[3:0],G[3:0],R[3:0]}
//     we         BRAM write enable, one cycle per pixel
//     frame_done one-cycle pulse at end of each captured frame
//     frame_err  sticky framing error for the current frame
interface cam_pixel_capture_if #(
  parameter int ADDR_W = 19
);
  logic              vsync;
  logic              href;
  logic [7:0]        d;
  logic [ADDR_W-1:0] addr;
  logic [11:0]       dout;
  logic              we;
  logic              frame_done;
  logic              frame_err;

  modport slave (
    input  vsync, href, d,
    output addr, dout, we, frame_done, frame_err
  );

  modport master (
    output vsync, href, d,
    input  addr, dout, we, frame_done, frame_err
  );
endinterface

// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture
//   Camera-side capture stage in front of the frame-buffer BRAM write port.
//   Registers the OV7670 bus, pairs bytes into 12-bit RGB444 pixels, and
//   writes them at line*H_ACTIVE + col. Flags end of frame and framing
//   errors so the top level can decide whether a frame is usable.
//   Ports:
//     clk    camera pixel clock (PCLK), the only clock
//     reset  asynchronous, active-high reset
//     bus    cam_pixel_capture_if.slave: vsync/href/d in,
//            addr/dout/we/frame_done/frame_err out
module cam_pixel_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  cam_pixel_capture_if.slave    bus
);

  localparam int COL_W  = 10;
  localparam int LINE_W = 9;

  localparam logic [COL_W-1:0]  H_LIM   = COL_W'(H_ACTIVE);
  localparam logic [LINE_W-1:0] V_LIM   = LINE_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LB_STEP = ADDR_W'(H_ACTIVE);

  typedef enum logic [1:0] {
    SYNC_WAIT,
    VBLANK,
    ACTIVE
  } state_t;

  state_t              state;
  logic                vsync_q;
  logic                href_q;
  logic                href_qq;
  logic [7:0]          d_q;
  logic [3:0]          hi;
  logic                phase;
  logic [COL_W-1:0]    col;
  logic [LINE_W-1:0]   line;
  logic [ADDR_W-1:0]   line_base;

  logic [ADDR_W-1:0]   addr_r;
  logic [11:0]         dout_r;
  logic                we_r;
  logic                frame_done_r;
  logic                frame_err_r;

  assign bus.addr       = addr_r;
  assign bus.dout       = dout_r;
  assign bus.we         = we_r;
  assign bus.frame_done = frame_done_r;
  assign bus.frame_err  = frame_err_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SYNC_WAIT;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      href_qq      <= 1'b0;
      d_q          <= '0;
      hi           <= '0;
      phase        <= 1'b0;
      col          <= '0;
      line         <= '0;
      line_base    <= '0;
      addr_r       <= '0;
      dout_r       <= '0;
      we_r         <= 1'b0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      // Input stage: everything below works only on the registered copies
      vsync_q <= bus.vsync;
      href_q  <= bus.href;
      d_q     <= bus.d;
      href_qq <= href_q;

      we_r         <= 1'b0;
      frame_done_r <= 1'b0;

      // Capture stage
      unique case (state)
        SYNC_WAIT: begin
          // Whatever frame is in flight after reset is incomplete; skip it
          if (vsync_q) state <= VBLANK;
        end

        VBLANK: begin
          phase     <= 1'b0;
          col       <= '0;
          line      <= '0;
          line_base <= '0;
          // VBLANK is only entered with vsync_q high, so a low here is the fall
          if (!vsync_q) begin
            state       <= ACTIVE;
            frame_err_r <= 1'b0;
          end
        end

        ACTIVE: begin
          if (vsync_q) begin
            state        <= VBLANK;
            frame_done_r <= 1'b1;
            if (href_q) frame_err_r <= 1'b1;
          end else if (href_q) begin
            if (!phase) begin
              hi    <= d_q[3:0];
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (col < H_LIM && line < V_LIM) begin
                we_r   <= 1'b1;
                dout_r <= {d_q[3:0], d_q[7:4], hi};
                addr_r <= line_base + ADDR_W'(col);
                col    <= col + 1'b1;
              end else begin
                // Overlong line or surplus line: drop the pixel
                frame_err_r <= 1'b1;
              end
            end
          end else if (href_qq) begin
            // Line end. col only advances on real writes, so line and
            // line_base stop at V_ACTIVE and the address stays in range.
            if (col != '0) begin
              line      <= line + 1'b1;
              line_base <= line_base + LB_STEP;
            end
            col   <= '0;
            phase <= 1'b0;
            if (phase) frame_err_r <= 1'b1;
          end
        end

        default: state <= SYNC_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
module tb_cam_pixel_capture;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int AW = 7;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [11:0]   p;
  } wr_t;

  logic clk;
  logic reset;

  cam_pixel_capture_if #(.ADDR_W(AW)) bus ();

  cam_pixel_capture #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .ADDR_W   (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_chk;
  int  n_fail;
  wr_t exp_q[$];
  int  wr_cnt;
  int  last_addr;
  int  done_cnt;
  int  exp_done;
  bit  exp_err;
  bit  armed;
  int  mline;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every write must match the oldest pending expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.we === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_we", 32'(bus.addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.addr), 32'(e.a));
          chk("wr_dout", 32'(bus.dout), 32'(e.p));
        end
        wr_cnt++;
        last_addr = int'(bus.addr);
      end
      if (bus.frame_done === 1'b1) done_cnt++;
    end
  end

  task automatic drive(input logic v, input logic h, input logic [7:0] dd);
    @(negedge clk);
    bus.vsync = v;
    bus.href  = h;
    bus.d     = dd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(bus.vsync, 1'b0, 8'h00);
  endtask

  task automatic push(input int a, input logic [11:0] p);
    wr_t e;
    e.a = AW'(a);
    e.p = p;
    exp_q.push_back(e);
  endtask

  // Drives npix pixels (plus one stray byte if odd); hold keeps href high
  task automatic send_line(input int npix, input bit odd, input bit hold);
    int wr;
    wr = 0;
    for (int p = 0; p < npix; p++) begin
      logic [11:0] pix;
      logic [3:0]  junk;
      pix  = 12'($urandom);
      junk = 4'($urandom);
      if (armed) begin
        if (p < H && mline < V) begin
          push(mline * H + p, pix);
          wr++;
        end else begin
          exp_err = 1'b1;
        end
      end
      drive(1'b0, 1'b1, {junk, pix[3:0]});
      drive(1'b0, 1'b1, {pix[7:4], pix[11:8]});
    end
    if (odd) begin
      drive(1'b0, 1'b1, 8'h5A);
      if (armed) exp_err = 1'b1;
    end
    if (!hold) begin
      idle(3);
      if (armed && wr > 0) mline++;
    end
  endtask

  // Ends the current frame and starts the next one
  task automatic vsync_pulse(input string tag);
    if (armed) exp_done++;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'h00);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
    chk({tag, "_err_vblank"}, 32'(bus.frame_err), 32'(exp_err));
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h00);
    exp_err = 1'b0;
    armed   = 1'b1;
    mline   = 0;
    chk({tag, "_err_cleared"}, 32'(bus.frame_err), 32'(exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; wr_cnt = 0; last_addr = -1;
    done_cnt = 0; exp_done = 0; exp_err = 1'b0; armed = 1'b0; mline = 0;
    bus.vsync = 1'b0; bus.href = 1'b0; bus.d = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(bus.we), 0);
    chk("rst_addr", 32'(bus.addr), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_done", 32'(bus.frame_done), 0);
    chk("rst_err", 32'(bus.frame_err), 0);
    reset = 1'b0;

    // Partial frame after reset: no writes until vsync high then low
    send_line(4, 1'b0, 1'b0);
    send_line(5, 1'b0, 1'b0);
    chk("pre_sync_wr_cnt", 32'(wr_cnt), 0);
    chk("pre_sync_err", 32'(bus.frame_err), 0);
    vsync_pulse("sync0");

    // Directed two-pixel line with latency checks
    push(0, 12'hC5A);
    push(1, 12'h1F3);
    drive(1'b0, 1'b1, 8'h0A);
    drive(1'b0, 1'b1, 8'h5C);
    @(posedge clk); #1 chk("lat_p0_early", 32'(bus.we), 0);
    drive(1'b0, 1'b1, 8'h03);
    @(posedge clk); #1 chk("lat_p0_we", 32'(bus.we), 1);
    drive(1'b0, 1'b1, 8'hF1);
    @(posedge clk); #1 chk("lat_p1_early", 32'(bus.we), 0);
    drive(1'b0, 1'b0, 8'h00);
    @(posedge clk); #1 chk("lat_p1_we", 32'(bus.we), 1);
    mline = 1;
    idle(3);
    chk("directed_wr_cnt", 32'(wr_cnt), 2);
    vsync_pulse("directed");

    // Full frame
    wr_cnt = 0;
    for (int l = 0; l < V; l++) send_line(H, 1'b0, 1'b0);
    vsync_pulse("full");
    chk("full_wr_cnt", 32'(wr_cnt), 32'(H * V));
    chk("full_last_addr", 32'(last_addr), 32'(H * V - 1));

    // Short line followed by full line
    send_line(10, 1'b0, 1'b0);
    send_line(H, 1'b0, 1'b0);
    vsync_pulse("short");

    // Overlong line
    send_line(H + 1, 1'b0, 1'b0);
    send_line(H, 1'b0, 1'b0);
    chk("overlong_err", 32'(bus.frame_err), 1);
    vsync_pulse("overlong");

    // Odd byte count
    send_line(1, 1'b1, 1'b0);
    send_line(2, 1'b0, 1'b0);
    chk("odd_err", 32'(bus.frame_err), 1);
    vsync_pulse("odd");

    // Surplus lines
    wr_cnt = 0;
    for (int l = 0; l < V + 1; l++) send_line(H, 1'b0, 1'b0);
    chk("extra_wr_cnt", 32'(wr_cnt), 32'(H * V));
    chk("extra_last_addr", 32'(last_addr), 32'(H * V - 1));
    vsync_pulse("extra");

    // Reset in the middle of a line
    send_line(H, 1'b0, 1'b0);
    send_line(5, 1'b0, 1'b1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("midrst_we", 32'(bus.we), 0);
    chk("midrst_addr", 32'(bus.addr), 0);
    chk("midrst_err", 32'(bus.frame_err), 0);
    exp_q.delete();
    armed = 1'b0; mline = 0; exp_err = 1'b0;
    bus.href = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wr_cnt = 0;
    send_line(6, 1'b0, 1'b0);
    chk("postrst_no_wr", 32'(wr_cnt), 0);
    vsync_pulse("postrst");
    send_line(3, 1'b0, 1'b0);
    chk("postrst_wr_cnt", 32'(wr_cnt), 3);
    chk("postrst_last_addr", 32'(last_addr), 2);
    vsync_pulse("final");

    idle(4);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
